// File: rtl/axi_aw_pkg.sv
// Shared definitions for the AW buffer: fixed-field payload layout and packed width helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: AW_FIXED_BITS, aw_fixed_t (cache..region, MSB first), aw_width().
package axi_aw_pkg;

   // cache(4) + prot(3) + lock(1) + burst(2) + size(3) + len(8) + qos(4) + region(4)
   localparam int AW_FIXED_BITS = 29;

   // Fixed-width AW fields, packed MSB-first in the order they sit in the FIFO word.
   typedef struct packed {
      logic [3:0] cache;
      logic [2:0] prot;
      logic       lock;
      logic [1:0] burst;
      logic [2:0] size;
      logic [7:0] len;
      logic [3:0] qos;
      logic [3:0] region;
   } aw_fixed_t;

   // Total packed AW beat width: {fixed, addr, user, id}.
   function automatic int aw_width(input int id_w, input int addr_w, input int user_w);
      return AW_FIXED_BITS + addr_w + user_w + id_w;
   endfunction

endpackage

// File: rtl/axi_fifo_sr.sv
// Generic circular FIFO with synchronous active-high reset and optional fall-through.
// Latency: 1 cycle push-to-output; 0 cycles when FALL_THROUGH=1 and the FIFO is empty.
// Backpressure: full stays high while DEPTH entries are held; a pop never frees a slot in the same cycle.
// Ports: clk/rst; push + data_in (write side); pop + data_out (read side); full, empty, fill (status).
module axi_fifo_sr
   import axi_aw_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int DEPTH        = 2,
   parameter bit FALL_THROUGH = 1'b0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic [DATA_WIDTH-1:0]        data_in,
   input  logic                         pop,
   output logic [DATA_WIDTH-1:0]        data_out,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   fill
);

   localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int FILL_W = $clog2(DEPTH + 1);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0]      wptr;
   logic [PTR_W-1:0]      rptr;
   logic                  is_empty;
   logic                  bypass;
   logic                  do_push;
   logic                  do_pop;

   // Pointers wrap at DEPTH-1 so non-power-of-two depths work.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign is_empty = (fill == '0);
   assign full     = (fill == FILL_W'(DEPTH));

   // In fall-through mode an empty FIFO forwards data_in directly; if that beat is
   // also popped it never touches storage.
   assign bypass  = FALL_THROUGH && is_empty && push && pop;
   assign do_push = push && !full && !bypass;
   assign do_pop  = pop && !is_empty;

   assign empty    = is_empty && !(FALL_THROUGH && push);
   assign data_out = (FALL_THROUGH && is_empty) ? data_in : mem[rptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wptr] <= data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
         fill <= '0;
      end else begin
         if (do_push) begin
            wptr <= ptr_inc(wptr);
         end
         if (do_pop) begin
            rptr <= ptr_inc(rptr);
         end
         case ({do_push, do_pop})
            2'b10:   fill <= fill + 1'b1;
            2'b01:   fill <= fill - 1'b1;
            default: fill <= fill;
         endcase
      end
   end

endmodule

// File: rtl/axi_aw_buffer_ot.sv
// AXI4 AW-channel buffer with an outstanding-write limiter driven by external B completions.
// Latency: 1 cycle slave-to-master (FALL_THROUGH=0); 0 cycles through an empty FIFO (FALL_THROUGH=1).
// Backpressure: slave_ready_o drops when the FIFO is full; master_valid_o is gated while the outstanding count is at its limit.
// Ports: clk_i/rst_i; slave_* AW input beat + slave_ready_o; master_* AW output beat + master_ready_i;
//        b_done_i completion strobe; fill_o, outstanding_o, underflow_o status.
module axi_aw_buffer_ot
   import axi_aw_pkg::*;
#(
   parameter int ID_WIDTH        = 4,
   parameter int ADDR_WIDTH      = 32,
   parameter int USER_WIDTH      = 6,
   parameter int BUFFER_DEPTH    = 2,
   parameter bit FALL_THROUGH    = 1'b0,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
   input  logic                                  slave_valid_i,
   input  logic [ADDR_WIDTH-1:0]                 slave_addr_i,
   input  logic [2:0]                            slave_prot_i,
   input  logic [3:0]                            slave_region_i,
   input  logic [7:0]                            slave_len_i,
   input  logic [2:0]                            slave_size_i,
   input  logic [1:0]                            slave_burst_i,
   input  logic                                  slave_lock_i,
   input  logic [3:0]                            slave_cache_i,
   input  logic [3:0]                            slave_qos_i,
   input  logic [ID_WIDTH-1:0]                   slave_id_i,
   input  logic [USER_WIDTH-1:0]                 slave_user_i,
   output logic                                  slave_ready_o,
   output logic                                  master_valid_o,
   output logic [ADDR_WIDTH-1:0]                 master_addr_o,
   output logic [2:0]                            master_prot_o,
   output logic [3:0]                            master_region_o,
   output logic [7:0]                            master_len_o,
   output logic [2:0]                            master_size_o,
   output logic [1:0]                            master_burst_o,
   output logic                                  master_lock_o,
   output logic [3:0]                            master_cache_o,
   output logic [3:0]                            master_qos_o,
   output logic [ID_WIDTH-1:0]                   master_id_o,
   output logic [USER_WIDTH-1:0]                 master_user_o,
   input  logic                                  master_ready_i,
   input  logic                                  b_done_i,
   output logic [$clog2(BUFFER_DEPTH+1)-1:0]     fill_o,
   output logic [((MAX_OUTSTANDING == 0) ? 1 : $clog2(MAX_OUTSTANDING+1))-1:0] outstanding_o,
   output logic                                  underflow_o
);

   localparam int AW_W = aw_width(ID_WIDTH, ADDR_WIDTH, USER_WIDTH);
   localparam int OT_W = (MAX_OUTSTANDING == 0) ? 1 : $clog2(MAX_OUTSTANDING + 1);

   aw_fixed_t       slave_fixed;
   aw_fixed_t       master_fixed;
   logic [AW_W-1:0] slave_pkt;
   logic [AW_W-1:0] master_pkt;

   logic            fifo_full;
   logic            fifo_empty;
   logic            push;
   logic            pop;
   logic            limit;
   logic            at_max;
   logic [OT_W-1:0] outstanding;
   logic            underflow;

   // ---------------- payload packing ----------------
   assign slave_fixed = '{
      cache:  slave_cache_i,
      prot:   slave_prot_i,
      lock:   slave_lock_i,
      burst:  slave_burst_i,
      size:   slave_size_i,
      len:    slave_len_i,
      qos:    slave_qos_i,
      region: slave_region_i
   };
   assign slave_pkt = {slave_fixed, slave_addr_i, slave_user_i, slave_id_i};
   assign {master_fixed, master_addr_o, master_user_o, master_id_o} = master_pkt;

   assign master_cache_o  = master_fixed.cache;
   assign master_prot_o   = master_fixed.prot;
   assign master_lock_o   = master_fixed.lock;
   assign master_burst_o  = master_fixed.burst;
   assign master_size_o   = master_fixed.size;
   assign master_len_o    = master_fixed.len;
   assign master_qos_o    = master_fixed.qos;
   assign master_region_o = master_fixed.region;

   // ---------------- handshakes ----------------
   // Both sides are forced idle during reset so nothing is accepted or issued
   // while the pointers and counters are being cleared.
   assign slave_ready_o  = !fifo_full && !rst_i;
   assign push           = slave_valid_i && slave_ready_o;
   assign master_valid_o = !fifo_empty && !limit && !rst_i;
   assign pop            = master_valid_o && master_ready_i;

   axi_fifo_sr #(
      .DATA_WIDTH   (AW_W),
      .DEPTH        (BUFFER_DEPTH),
      .FALL_THROUGH (FALL_THROUGH)
   ) u_fifo (
      .clk      (clk_i),
      .rst      (rst_i),
      .push     (push),
      .data_in  (slave_pkt),
      .pop      (pop),
      .data_out (master_pkt),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .fill     (fill_o)
   );

   // ---------------- outstanding limiter ----------------
   // The gate looks only at the registered count, so a B completion releases
   // the limit one cycle later and an asserted valid can never be withdrawn
   // (the count only climbs on a handshake).
   assign limit  = (MAX_OUTSTANDING != 0) && (outstanding == OT_W'(MAX_OUTSTANDING));
   assign at_max = (MAX_OUTSTANDING == 0) ? (outstanding == '1)
                                          : (outstanding == OT_W'(MAX_OUTSTANDING));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         outstanding <= '0;
         underflow   <= 1'b0;
      end else begin
         if (b_done_i && (outstanding == '0)) begin
            underflow <= 1'b1;
         end
         if (pop && !b_done_i && !at_max) begin
            outstanding <= outstanding + 1'b1;
         end else if (b_done_i && !pop && (outstanding != '0)) begin
            outstanding <= outstanding - 1'b1;
         end
      end
   end

   assign outstanding_o = outstanding;
   assign underflow_o   = underflow;

endmodule

// File: doc/axi_aw_buffer_ot.md
Name: axi_aw_buffer_ot

Overview:
Parametrised successor AW-channel slice: buffers AXI4 write-address beats in a configurable-depth FIFO.
- Optional fall-through mode for zero-latency forwarding when the FIFO is empty.
- Limits outstanding write transactions by counting issued AW beats against completed B responses.
- Exposes fill level and an underflow error flag.
- Sits between the interconnect master port and a downstream slave that needs bounded write concurrency.

Parameters:
ID_WIDTH, 4, AW id width
ADDR_WIDTH, 32, address width
USER_WIDTH, 6, user sideband width
BUFFER_DEPTH, 2, FIFO entries (>=1, any integer)
FALL_THROUGH, 0, 1 = combinational bypass when FIFO empty; 0 = registered output
MAX_OUTSTANDING, 4, maximum issued-but-unresponded writes; 0 = no limit

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
slave_valid_i  in  1  AW valid from upstream
slave_addr_i/prot_i/region_i/len_i/size_i/burst_i/lock_i/cache_i/qos_i/id_i/user_i  in  ADDR_WIDTH/3/4/8/3/2/1/4/4/ID_WIDTH/USER_WIDTH  AW payload
slave_ready_o  out  1  AW ready to upstream
master_valid_o  out  1  AW valid downstream
master_addr_o ... master_user_o  out  same widths  AW payload downstream
master_ready_i  in  1  AW ready from downstream
b_done_i  in  1  one B handshake completed this cycle (bvalid & bready, observed externally)
fill_o  out  $clog2(BUFFER_DEPTH+1)  FIFO entries currently held
outstanding_o  out  $clog2(MAX_OUTSTANDING+1) (min 1)  issued-not-responded count
underflow_o  out  1  sticky: b_done_i seen while outstanding==0

Behaviour:
- One clock. Reset is synchronous and active-high.
- While rst_i=1, at the next edge: pointers, fill, outstanding and underflow clear to 0. slave_ready_o=0 and master_valid_o=0 combinationally during any cycle with rst_i=1.
- Reset mid-burst discards all buffered entries. No partial state survives.
- Payload packing: 29 fixed bits + ADDR_WIDTH + USER_WIDTH + ID_WIDTH, in the order {cache, prot, lock, burst, size, len, qos, region, addr, user, id}.
- FIFO:
  - Circular buffer. Write/read pointers wrap from BUFFER_DEPTH-1 to 0.
  - slave_ready_o = (fill < BUFFER_DEPTH), independent of slave_valid_i.
  - Push on slave_valid_i & slave_ready_o. Pop on master_valid_o & master_ready_i.
  - Full with a simultaneous pop: ready stays 0 (no combinational ready-through). Push and pop in the same cycle: fill unchanged.
- Output side, FALL_THROUGH=0:
  - Data is visible one cycle after the push edge at the earliest.
  - master_valid_o = (fill>0) & ~limit.
  - Full throughput: one beat/cycle sustained when BUFFER_DEPTH>=2.
- Output side, FALL_THROUGH=1:
  - With fill==0 and slave_valid_i=1, the slave payload drives the master outputs combinationally.
  - master_valid_o = slave_valid_i & ~limit.
  - If master_ready_i=1 the beat bypasses the FIFO (no write). Otherwise it is written and fill becomes 1.
- Limit = (MAX_OUTSTANDING!=0) & (outstanding == MAX_OUTSTANDING), using the registered count only. A b_done_i in the same cycle does not release the limit until the next cycle.
- AXI stability: once master_valid_o=1 it stays 1 with a stable payload until handshake. This holds because outstanding only rises on a handshake.
- Outstanding counter:
  - +1 on AW master handshake, -1 on b_done_i; both in the same cycle leaves it unchanged.
  - b_done_i with outstanding==0: counter holds 0 and underflow_o sets, clearing only on reset.
  - Counter never exceeds MAX_OUTSTANDING.
  - When MAX_OUTSTANDING=0 the counter saturates at its width maximum and never gates.

Decomposition:
- Shared package axi_aw_pkg:
  - AW_FIXED_BITS=29.
  - Function aw_width(id, addr, user).
  - Packed struct typedef for the AW payload field order.
- Sub-module axi_fifo_sr: generic synchronous-reset, active-high FIFO with parameters DATA_WIDTH, DEPTH, FALL_THROUGH, and ports push/pop/data/full/empty/fill.
- Top-level owns packing, the limit gate and the outstanding/underflow logic.

Test Plan:
- Reset, then BUFFER_DEPTH=2, FALL_THROUGH=0, master_ready_i=1; push addr 0x1000, 0x2000 on consecutive cycles -> master sees 0x1000 one cycle after push, then 0x2000; fill_o peaks at 1; no lost or duplicated beats.
- master_ready_i=0; push 3 beats into depth 2 -> slave_ready_o=0 after 2 accepts, fill_o=2. Raise ready -> drains in order, third beat accepted the cycle after the first pop.
- FALL_THROUGH=1, empty FIFO, slave_valid_i=1, master_ready_i=1, addr 0xABCD -> master_addr_o=0xABCD in the same cycle, fill_o stays 0.
- MAX_OUTSTANDING=2; issue 3 AWs with downstream ready and no b_done_i -> two handshakes, master_valid_o=0 while outstanding_o=2. Pulse b_done_i -> third AW issues the following cycle, not the same cycle.
- Same-cycle AW handshake and b_done_i at outstanding_o=1 -> outstanding_o stays 1. Pulse b_done_i at outstanding_o=0 -> underflow_o=1, held until rst_i.
- Assert rst_i for 1 cycle with fill_o=2 and outstanding_o=2 -> next cycle: all counts 0, master_valid_o=0, old data never emitted.
